// File: rtl/skin_mask_bbox.sv
// Skin-colour classifier and per-frame bounding-box accumulator.
// Classifies each H/S/V pixel against inclusive windows, emits a 1-cycle
// delayed mask aligned with the re-registered syncs, and publishes the
// skin bounding box and pixel count of each complete frame on vsync rise.
module skin_mask_bbox #(
  parameter logic [7:0] H_MIN = 8'd0,
  parameter logic [7:0] H_MAX = 8'd35,
  parameter logic [7:0] S_MIN = 8'd40,
  parameter logic [7:0] S_MAX = 8'd255,
  parameter logic [7:0] V_MIN = 8'd50,
  parameter logic [7:0] V_MAX = 8'd255,
  parameter int         XW    = 11,
  parameter int         YW    = 11,
  parameter int         CW    = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [7:0]    H,
  input  logic [7:0]    S,
  input  logic [7:0]    V,
  input  logic          in_hsync,
  input  logic          in_vsync,
  input  logic          in_de,
  output logic          mask,
  output logic          out_hsync,
  output logic          out_vsync,
  output logic          out_de,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] skin_count,
  output logic          bbox_valid,
  output logic          frame_done
);

  typedef enum logic {WAIT_SYNC, ACTIVE} state_t;

  localparam logic [XW-1:0] X_ONES = '1;
  localparam logic [YW-1:0] Y_ONES = '1;
  localparam logic [CW-1:0] C_ONES = '1;

  // Window test done as a modular offset: x - lo <= hi - lo (mod 256).
  // With lo > hi this naturally becomes the wrapped window, which is what
  // hue wants; saturation/value windows with lo > hi are simply empty.
  function automatic logic in_window(input logic [7:0] x,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi,
                                     input logic       wrap);
    logic [7:0] off;
    logic [7:0] span;
    off  = x - lo;
    span = hi - lo;
    if (!wrap && (lo > hi))
      return 1'b0;
    return off <= span;
  endfunction

  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] a);
    return (a == X_ONES) ? a : a + 1'b1;
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] a);
    return (a == Y_ONES) ? a : a + 1'b1;
  endfunction

  function automatic logic [CW-1:0] sat_inc_c(input logic [CW-1:0] a);
    return (a == C_ONES) ? a : a + 1'b1;
  endfunction

  state_t        state;
  logic          mask_p1, hs_p1, vs_p1, vld_p1;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [XW-1:0] run_xmin, run_xmax;
  logic [YW-1:0] run_ymin, run_ymax;
  logic [CW-1:0] run_count;

  logic          skin_p0;
  logic          vs_rise_p0;
  logic          de_fall_p0;
  logic [XW-1:0] nxt_xmin, nxt_xmax;
  logic [YW-1:0] nxt_ymin, nxt_ymax;
  logic [CW-1:0] nxt_count;

  // ---- stage p0: classification, edge detection, accumulator next-state
  assign skin_p0 = in_de
                 & in_window(H, H_MIN, H_MAX, 1'b1)
                 & in_window(S, S_MIN, S_MAX, 1'b0)
                 & in_window(V, V_MIN, V_MAX, 1'b0);

  // Registered syncs double as the ce-qualified previous samples.
  assign vs_rise_p0 = in_vsync & ~vs_p1;
  assign de_fall_p0 = ~in_de & vld_p1;

  // Accumulators merged with the current pixel, so a skin pixel on the
  // vsync-rise cycle still lands in the frame being closed.
  always_comb begin
    nxt_xmin  = run_xmin;
    nxt_xmax  = run_xmax;
    nxt_ymin  = run_ymin;
    nxt_ymax  = run_ymax;
    nxt_count = run_count;
    if (skin_p0) begin
      if (x_cnt < run_xmin) nxt_xmin = x_cnt;
      if (x_cnt > run_xmax) nxt_xmax = x_cnt;
      if (y_cnt < run_ymin) nxt_ymin = y_cnt;
      if (y_cnt > run_ymax) nxt_ymax = y_cnt;
      nxt_count = sat_inc_c(run_count);
    end
  end

  // ---- stage p1: registered mask/syncs, counters, FSM and published results
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SYNC;
      mask_p1    <= 1'b0;
      hs_p1      <= 1'b0;
      vs_p1      <= 1'b0;
      vld_p1     <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      run_xmin   <= X_ONES;
      run_xmax   <= '0;
      run_ymin   <= Y_ONES;
      run_ymax   <= '0;
      run_count  <= '0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      skin_count <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (ce) begin
      mask_p1    <= skin_p0;
      hs_p1      <= in_hsync;
      vs_p1      <= in_vsync;
      vld_p1     <= in_de;
      frame_done <= 1'b0;

      x_cnt <= in_de ? sat_inc_x(x_cnt) : '0;
      if (vs_rise_p0)
        y_cnt <= '0;
      else if (de_fall_p0)
        y_cnt <= sat_inc_y(y_cnt);

      case (state)
        WAIT_SYNC: begin
          // Partial frame after reset: keep accumulators cleared.
          run_xmin  <= X_ONES;
          run_xmax  <= '0;
          run_ymin  <= Y_ONES;
          run_ymax  <= '0;
          run_count <= '0;
          if (vs_rise_p0)
            state <= ACTIVE;
        end
        ACTIVE: begin
          if (vs_rise_p0) begin
            if (nxt_count != '0) begin
              x_min <= nxt_xmin;
              x_max <= nxt_xmax;
              y_min <= nxt_ymin;
              y_max <= nxt_ymax;
            end else begin
              x_min <= '0;
              x_max <= '0;
              y_min <= '0;
              y_max <= '0;
            end
            skin_count <= nxt_count;
            bbox_valid <= (nxt_count != '0);
            frame_done <= 1'b1;
            run_xmin   <= X_ONES;
            run_xmax   <= '0;
            run_ymin   <= Y_ONES;
            run_ymax   <= '0;
            run_count  <= '0;
          end else begin
            run_xmin  <= nxt_xmin;
            run_xmax  <= nxt_xmax;
            run_ymin  <= nxt_ymin;
            run_ymax  <= nxt_ymax;
            run_count <= nxt_count;
          end
        end
        default: state <= WAIT_SYNC;
      endcase
    end
  end

  assign mask      = mask_p1;
  assign out_hsync = hs_p1;
  assign out_vsync = vs_p1;
  assign out_de    = vld_p1;

endmodule

// File: tb/tb_skin_mask_bbox.sv
// Testbench for skin_mask_bbox: two instances (default hue window and a
// wrapped 240..10 hue window) driven with the same pixel stream and checked
// every cycle against a frame-level reference model.
module tb_skin_mask_bbox;

  logic       clk = 1'b0;
  logic       rst, ce, in_hsync, in_vsync, in_de;
  logic [7:0] h_in, s_in, v_in;

  logic        mask_o [2];
  logic        ohs    [2];
  logic        ovs    [2];
  logic        ode    [2];
  logic        bv     [2];
  logic        fd     [2];
  logic [10:0] xmn    [2];
  logic [10:0] xmx    [2];
  logic [10:0] ymn    [2];
  logic [10:0] ymx    [2];
  logic [21:0] cnt    [2];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit m_prev_vs, m_active, e_fd, e_de, e_hs, e_vs;
  bit e_mask [2];
  bit e_valid[2];
  int e_xmin[2], e_xmax[2], e_ymin[2], e_ymax[2], e_cnt[2];
  int fr_xmin[2], fr_xmax[2], fr_ymin[2], fr_ymax[2], fr_cnt[2];

  skin_mask_bbox dut0 (
    .clk(clk), .rst(rst), .ce(ce), .H(h_in), .S(s_in), .V(v_in),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .mask(mask_o[0]), .out_hsync(ohs[0]), .out_vsync(ovs[0]), .out_de(ode[0]),
    .x_min(xmn[0]), .x_max(xmx[0]), .y_min(ymn[0]), .y_max(ymx[0]),
    .skin_count(cnt[0]), .bbox_valid(bv[0]), .frame_done(fd[0])
  );

  skin_mask_bbox #(.H_MIN(8'd240), .H_MAX(8'd10)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .H(h_in), .S(s_in), .V(v_in),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .mask(mask_o[1]), .out_hsync(ohs[1]), .out_vsync(ovs[1]), .out_de(ode[1]),
    .x_min(xmn[1]), .x_max(xmx[1]), .y_min(ymn[1]), .y_max(ymx[1]),
    .skin_count(cnt[1]), .bbox_valid(bv[1]), .frame_done(fd[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, d, obs, exp);
    end
  endtask

  function automatic bit skin_ref(input int h, input int s, input int v, input int d);
    int  hmin, hmax;
    bit  hue_ok;
    hmin = (d == 1) ? 240 : 0;
    hmax = (d == 1) ? 10  : 35;
    if (hmin <= hmax) hue_ok = (h >= hmin) && (h <= hmax);
    else              hue_ok = (h >= hmin) || (h <= hmax);
    return hue_ok && (s >= 40) && (s <= 255) && (v >= 50) && (v <= 255);
  endfunction

  task automatic fr_clear();
    for (int d = 0; d < 2; d++) begin
      fr_xmin[d] = 2047; fr_xmax[d] = 0;
      fr_ymin[d] = 2047; fr_ymax[d] = 0;
      fr_cnt[d]  = 0;
    end
  endtask

  // One clock cycle: apply inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                     input logic hs, input logic vs, input logic de,
                     input logic ce_i, input logic rst_i, input int px, input int py);
    bit sk, rise;
    h_in = h; s_in = s; v_in = v;
    in_hsync = hs; in_vsync = vs; in_de = de; ce = ce_i; rst = rst_i;
    if (rst_i) begin
      m_prev_vs = 0; m_active = 0; e_fd = 0; e_de = 0; e_hs = 0; e_vs = 0;
      for (int d = 0; d < 2; d++) begin
        e_mask[d] = 0; e_valid[d] = 0;
        e_xmin[d] = 0; e_xmax[d] = 0; e_ymin[d] = 0; e_ymax[d] = 0; e_cnt[d] = 0;
      end
      fr_clear();
    end else if (ce_i) begin
      rise = vs && !m_prev_vs;
      m_prev_vs = vs;
      e_de = de; e_hs = hs; e_vs = vs; e_fd = 0;
      for (int d = 0; d < 2; d++) begin
        sk = de && skin_ref(int'(h), int'(s), int'(v), d);
        e_mask[d] = sk;
        if (m_active && sk) begin
          if (px < fr_xmin[d]) fr_xmin[d] = px;
          if (px > fr_xmax[d]) fr_xmax[d] = px;
          if (py < fr_ymin[d]) fr_ymin[d] = py;
          if (py > fr_ymax[d]) fr_ymax[d] = py;
          fr_cnt[d]++;
        end
      end
      if (rise) begin
        if (m_active) begin
          e_fd = 1;
          for (int d = 0; d < 2; d++) begin
            e_valid[d] = (fr_cnt[d] != 0);
            e_cnt[d]   = fr_cnt[d];
            e_xmin[d]  = e_valid[d] ? fr_xmin[d] : 0;
            e_xmax[d]  = e_valid[d] ? fr_xmax[d] : 0;
            e_ymin[d]  = e_valid[d] ? fr_ymin[d] : 0;
            e_ymax[d]  = e_valid[d] ? fr_ymax[d] : 0;
          end
        end
        m_active = 1;
        fr_clear();
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mask",       d, 32'(mask_o[d]), 32'(e_mask[d]));
      chk("out_de",     d, 32'(ode[d]),    32'(e_de));
      chk("out_hsync",  d, 32'(ohs[d]),    32'(e_hs));
      chk("out_vsync",  d, 32'(ovs[d]),    32'(e_vs));
      chk("frame_done", d, 32'(fd[d]),     32'(e_fd));
      chk("x_min",      d, 32'(xmn[d]),    e_xmin[d]);
      chk("x_max",      d, 32'(xmx[d]),    e_xmax[d]);
      chk("y_min",      d, 32'(ymn[d]),    e_ymin[d]);
      chk("y_max",      d, 32'(ymx[d]),    e_ymax[d]);
      chk("skin_count", d, 32'(cnt[d]),    e_cnt[d]);
      chk("bbox_valid", d, 32'(bv[d]),     32'(e_valid[d]));
    end
  endtask

  // mode 0: random pixels, 1: skin block cols 10..19 rows 5..7, 2: no skin
  task automatic run_frame(input int w, input int h, input int mode, input bit gaps,
                           input int rst_line, input bit vs_last);
    logic [7:0] ph, ps, pv;
    bit last;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        ph = 8'd100; ps = 8'd100; pv = 8'd100;
        if (mode == 0) begin
          if ($urandom_range(0, 1) == 1) begin
            ph = 8'($urandom_range(0, 35));
            ps = 8'($urandom_range(40, 255));
            pv = 8'($urandom_range(50, 255));
          end else begin
            ph = 8'($urandom_range(0, 255));
            ps = 8'($urandom_range(0, 255));
            pv = 8'($urandom_range(0, 255));
          end
        end else if (mode == 1) begin
          if (c >= 10 && c <= 19 && r >= 5 && r <= 7) ph = 8'd20;
        end
        if (gaps && c == w / 2)
          repeat (3) cyc(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)), 1'b0, 1'b0,
                         1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 0);
        last = vs_last && (r == h - 1) && (c == w - 1);
        if (last) ph = 8'd20;
        if (last) begin ps = 8'd100; pv = 8'd100; end
        cyc(ph, ps, pv, 1'b0, last, 1'b1, 1'b1, (r == rst_line) && (c == w / 2), c, r);
      end
      for (int b = 0; b < 4; b++)
        cyc(8'd0, 8'd0, 8'd0, (b == 1) || (b == 2), vs_last && (r == h - 1),
            1'b0, 1'b1, 1'b0, 0, 0);
    end
  endtask

  task automatic close_frame(input bit ce_low);
    if (ce_low)
      repeat (3) cyc(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    cyc(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (3) cyc(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
    h_in = 8'd0; s_in = 8'd0; v_in = 8'd0;
    fr_clear();

    // reset state
    repeat (3) cyc(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);

    // classification, window boundaries and hue wrap
    cyc(8'd20,  8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("cls_skin", 0, 32'(mask_o[0]), 32'd1);
    cyc(8'd100, 8'd100, 8'd100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
    chk("cls_nonskin", 0, 32'(mask_o[0]), 32'd0);
    cyc(8'd35,  8'd40,  8'd50,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0);
    cyc(8'd36,  8'd40,  8'd50,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0);
    cyc(8'd20,  8'd39,  8'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0);
    cyc(8'd20,  8'd100, 8'd49,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5, 0);
    cyc(8'd0,   8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6, 0);
    cyc(8'd250, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7, 0);
    chk("wrap_250", 1, 32'(mask_o[1]), 32'd1);
    cyc(8'd5,   8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8, 0);
    chk("wrap_5", 1, 32'(mask_o[1]), 32'd1);
    cyc(8'd128, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9, 0);
    chk("wrap_128", 1, 32'(mask_o[1]), 32'd0);
    cyc(8'd20,  8'd100, 8'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    chk("mask_de_low", 0, 32'(mask_o[0]), 32'd0);
    repeat (2) cyc(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    // first vsync only arms the accumulator (no publish)
    close_frame(1'b0);

    // 64x48 frame with a 10x3 skin block
    run_frame(64, 48, 1, 1'b0, -1, 1'b0);
    close_frame(1'b0);
    chk("blk_x_min", 0, 32'(xmn[0]), 32'd10);
    chk("blk_x_max", 0, 32'(xmx[0]), 32'd19);
    chk("blk_y_min", 0, 32'(ymn[0]), 32'd5);
    chk("blk_y_max", 0, 32'(ymx[0]), 32'd7);
    chk("blk_count", 0, 32'(cnt[0]), 32'd30);
    chk("blk_valid", 0, 32'(bv[0]),  32'd1);

    // random frame with 3-cycle ce stalls mid-line
    run_frame(16, 6, 0, 1'b1, -1, 1'b0);
    close_frame(1'b0);

    // skin pixel on the vsync-rise cycle, then an empty frame
    run_frame(16, 6, 0, 1'b0, -1, 1'b1);
    repeat (3) cyc(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    close_frame(1'b0);

    // random frame closed with ce low across the vsync edge
    run_frame(16, 6, 0, 1'b0, -1, 1'b0);
    close_frame(1'b1);

    // reset mid-frame: partial frame not published, then empty full frame
    run_frame(16, 6, 0, 1'b0, 2, 1'b0);
    close_frame(1'b0);
    run_frame(16, 6, 2, 1'b0, -1, 1'b0);
    close_frame(1'b0);
    chk("empty_valid", 0, 32'(bv[0]),  32'd0);
    chk("empty_count", 0, 32'(cnt[0]), 32'd0);

    // final random frame
    run_frame(20, 8, 0, 1'b0, -1, 1'b0);
    close_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
